if_id_pipeline: RTL
===================

// Module: if_id_pipeline
// PURPOSE
//  Fetch stage plus IF/ID pipeline register, directly upstream of the ID/EXE register.
//  Owns the PC and drives the instruction-memory address.
//  Latches the fetched word and PC+4 for decode.
//  Detects load-use hazards against the instruction now in EXE; stalls, or flushes on a taken branch.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset
//  NOP_INSTR  32'h0000_0000  word injected into IF/ID on flush/reset (ANDEQ r0,r0,r0)
//  CNT_W      16             width of stall performance counter
// PORTS
//  clk              in   1      single clock, rising edge
//  reset            in   1      asynchronous, active-high
//  imem_addr        out  32     instruction memory address (= PC, combinational)
//  imem_data        in   32     instruction word for imem_addr, valid same cycle
//  freeze           in   1      global pipeline freeze (memory wait); holds all state
//  branch_taken     in   1      taken branch resolved in EXE
//  branch_target    in   32     target address when branch_taken
//  EXE_load_instr   in   1      instruction in EXE is a load
//  EXE_RF_enable    in   1      instruction in EXE writes the register file
//  EXE_Rd_num       in   4      destination register of instruction in EXE
//  ID_instruction   out  32     IF/ID latched instruction
//  ID_PC            out  32     IF/ID latched PC+4 of that instruction
//  ID_valid         out  1      IF/ID holds a real (non-bubble) instruction
//  hazard_stall     out  1      load-use stall; ID forces control signals to 0 into ID/EXE
//  stall_count      out  CNT_W  number of hazard-stall cycles since reset, saturating
// BEHAVIOUR
//  Reset values (async, while reset=1):
//   PC=RESET_PC, ID_instruction=NOP_INSTR, ID_PC=0, ID_valid=0, stall_count=0.
//  hazard_stall (combinational) =
//   ID_valid & EXE_load_instr & EXE_RF_enable &
//   ((ID_instruction[19:16]==EXE_Rd_num) | (ID_instruction[3:0]==EXE_Rd_num)).
//   Compare is conservative: both fields are always checked, whatever the instruction class.
//  Per rising edge, first matching case wins:
//   1 freeze=1: PC, IF/ID and stall_count all hold.
//   2 branch_taken=1:
//     PC<=branch_target, ID_instruction<=NOP_INSTR, ID_valid<=0, ID_PC holds.
//     Branch beats a simultaneous hazard_stall; no stall is counted.
//   3 hazard_stall=1:
//     PC and IF/ID hold; stall_count increments, saturating at all-ones.
//   4 otherwise:
//     PC<=PC+4 (mod 2^32, wraps 0xFFFF_FFFC->0), ID_instruction<=imem_data, ID_PC<=PC+4, ID_valid<=1.
//  Latency: imem_data appears on ID_instruction one cycle after its address is on imem_addr.
//  Stall lasts exactly one cycle per load-use pair.
//   The bubble then in EXE has EXE_load_instr=0, so hazard_stall deasserts.
//  branch_target is used as-is; no alignment check.
//  Reset mid-stall or mid-flush returns to the reset values; the first fetch after release is from RESET_PC.
//  freeze with branch_taken: the branch is not taken this cycle.
//   EXE is also frozen, so branch_taken persists and takes effect on the first unfrozen edge.
// STRUCTURE
//  Shared package/include holds:
//   NOP_INSTR and PC_STEP=4 constants;
//   field positions RN_HI=19, RN_LO=16, RM_HI=3, RM_LO=0, RD_HI=15, RD_LO=12 (also used by ID/EXE).
//  Sub-module load_use_hazard_unit holds the hazard compare.
//   It is combinational and is reused later by the forwarding work.
//  PC register, IF/ID register and counter stay in the top level.
// TESTING
//  T1 Reset then 4 free-running cycles:
//     imem_addr = 0, 4, 8, 12; ID_PC = 4, 8, 12 lagging by one cycle; ID_valid rises one cycle after reset.
//  T2 ID holds 32'hE081_2003 (Rn=1, Rm=3); EXE_load_instr=1, EXE_RF_enable=1, EXE_Rd_num=3:
//     hazard_stall=1 for one cycle, PC and ID_instruction held, stall_count 0->1.
//  T3 Same as T2 with EXE_Rd_num=2 (no match), or with EXE_RF_enable=0:
//     no stall, PC advances by 4.
//  T4 branch_taken=1, target 32'h0000_0100, with hazard active the same cycle:
//     next imem_addr=0x100, ID_instruction=NOP_INSTR, ID_valid=0, stall_count unchanged.
//  T5 freeze=1 for 3 cycles with branch_taken=1:
//     everything holds; the branch applies on the first cycle freeze=0.
//  T6 Force PC=0xFFFF_FFFC via branch, then no stall: next PC=0.
//     Preload stall_count to 0xFFFF and stall: it stays 0xFFFF.
//     Assert reset asynchronously mid-stall: outputs reach reset values before the next edge.

Source files
------------

// File: rtl/if_id_pipeline_pkg.sv
// Shared constants and bundles for the fetch / decode boundary.
// Field positions are also consumed by the ID/EXE stage.
package if_id_pipeline_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;

  localparam int RN_HI = 19;
  localparam int RN_LO = 16;
  localparam int RM_HI = 3;
  localparam int RM_LO = 0;
  localparam int RD_HI = 15;
  localparam int RD_LO = 12;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
  } if_id_t;

  function automatic logic [3:0] rn_of(
    input logic [31:0] instr
  );
    return instr[RN_HI:RN_LO];
  endfunction

  function automatic logic [3:0] rm_of(
    input logic [31:0] instr
  );
    return instr[RM_HI:RM_LO];
  endfunction

endpackage

// File: rtl/if_id_pipeline_hazard.sv
// Load-use hazard compare between the word in ID and the load in EXE.
// Both source fields are checked regardless of instruction class.
module load_use_hazard_unit
  import if_id_pipeline_pkg::*;
(
  input  logic        id_valid,
  input  logic [31:0] id_instr,
  input  logic        exe_load,
  input  logic        exe_rf_en,
  input  logic [3:0]  exe_rd,
  output logic        stall
);

  logic rn_hit;
  logic rm_hit;

  assign rn_hit = (rn_of(id_instr) == exe_rd);
  assign rm_hit = (rm_of(id_instr) == exe_rd);

  assign stall = id_valid
               & exe_load
               & exe_rf_en
               & (rn_hit | rm_hit);

endmodule

// File: rtl/if_id_pipeline.sv
// Fetch stage: PC register, IF/ID register and stall counter.
// Branch beats stall; freeze beats everything.
module if_id_pipeline
  import if_id_pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = if_id_pipeline_pkg::NOP_INSTR,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_data,
  input  logic             freeze,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  input  logic             EXE_load_instr,
  input  logic             EXE_RF_enable,
  input  logic [3:0]       EXE_Rd_num,
  output logic [31:0]      ID_instruction,
  output logic [31:0]      ID_PC,
  output logic             ID_valid,
  output logic             hazard_stall,
  output logic [CNT_W-1:0] stall_count
);

  logic [31:0]      pc_q;
  logic [31:0]      pc_d;
  logic [31:0]      pc_plus4;
  if_id_t           if_id_q;
  if_id_t           if_id_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic do_branch;
  logic do_stall;
  logic do_adv;

  load_use_hazard_unit u_hazard (
    .id_valid  (if_id_q.valid),
    .id_instr  (if_id_q.instr),
    .exe_load  (EXE_load_instr),
    .exe_rf_en (EXE_RF_enable),
    .exe_rd    (EXE_Rd_num),
    .stall     (hazard_stall)
  );

  assign pc_plus4 = pc_q + PC_STEP;

  // One-hot action so the decoder below never sees overlap.
  assign do_branch = !freeze & branch_taken;
  assign do_stall  = !freeze & !branch_taken & hazard_stall;
  assign do_adv    = !freeze & !branch_taken & !hazard_stall;

  always_comb begin
    pc_d    = pc_q;
    if_id_d = if_id_q;
    cnt_d   = cnt_q;
    unique case (1'b1)
      do_branch: begin
        pc_d          = branch_target;
        if_id_d.instr = NOP_INSTR;
        if_id_d.valid = 1'b0;
      end
      do_stall: begin
        if (cnt_q != '1)
          cnt_d = cnt_q + CNT_W'(1);
      end
      do_adv: begin
        pc_d          = pc_plus4;
        if_id_d.instr = imem_data;
        if_id_d.pc    = pc_plus4;
        if_id_d.valid = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      if_id_q.instr <= NOP_INSTR;
      if_id_q.pc    <= '0;
      if_id_q.valid <= 1'b0;
      cnt_q         <= '0;
    end else begin
      pc_q    <= pc_d;
      if_id_q <= if_id_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem_addr      = pc_q;
  assign ID_instruction = if_id_q.instr;
  assign ID_PC          = if_id_q.pc;
  assign ID_valid       = if_id_q.valid;
  assign stall_count    = cnt_q;

endmodule
